// File: rtl/alu4_pkg.sv
// Shared types and opcode constants for the 4-bit ALU command sequencer.
package alu4_pkg;

  localparam int unsigned ALU_W = 4;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_NOT   = 3'b101;
  localparam logic [2:0] OP_PASSB = 3'b110;
  localparam logic [2:0] OP_PASSA = 3'b111;

  typedef struct packed {
    logic [2:0]       sel;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic             use_acc;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } seq_state_e;

endpackage

// File: rtl/alu4_cmd_fifo.sv
// Synchronous command FIFO; Depth must be a power of two so pointers wrap naturally.
module alu4_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic [Width-1:0] mem_q [Depth];
  logic             push_en, pop_en;

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_en) wptr_d = wptr_q + 1'b1;
    if (pop_en)  rptr_d = rptr_q + 1'b1;
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu4_cmd_sequencer.sv
// Queues ALU commands, issues them one at a time to an external alu4bit and returns results.
// Optional ALU_SEQ_STATS_EN adds saturating op/carry counters.
module alu4_cmd_sequencer
  import alu4_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_sel_i,
  input  logic [ALU_W-1:0] cmd_a_i,
  input  logic [ALU_W-1:0] cmd_b_i,
  input  logic             cmd_use_acc_i,
  output logic [ALU_W-1:0] alu_a_o,
  output logic [ALU_W-1:0] alu_b_o,
  output logic [2:0]       alu_sel_o,
  input  logic [ALU_W-1:0] alu_result_i,
  input  logic             alu_carry_i,
  input  logic             alu_zero_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [ALU_W-1:0] rsp_result_o,
  output logic             rsp_carry_o,
  output logic             rsp_zero_o,
`ifdef ALU_SEQ_STATS_EN
  output logic [15:0]      stat_ops_o,
  output logic [15:0]      stat_carry_o,
`endif
  output logic [ALU_W-1:0] acc_o
);

  localparam int unsigned Width = ALU_W;

  seq_state_e       state_q, state_d;
  logic [Width-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]       alu_sel_q, alu_sel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [Width-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [Width-1:0] acc_q, acc_d;

  alu_cmd_t push_cmd, head_cmd;
  logic     fifo_full, fifo_empty, fifo_pop, issue;

  assign push_cmd = {cmd_sel_i, cmd_a_i, cmd_b_i, cmd_use_acc_i};

  alu4_cmd_fifo #(
    .Depth(Depth),
    .Width($bits(alu_cmd_t))
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (cmd_valid_i),
    .wdata_i(push_cmd),
    .pop_i  (fifo_pop),
    .rdata_o(head_cmd),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign cmd_ready_o = !fifo_full;

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    acc_d        = acc_q;
    issue        = 1'b0;
    fifo_pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          issue   = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        rsp_result_d = alu_result_i;
        rsp_carry_d  = alu_carry_i;
        rsp_zero_d   = alu_zero_i;
        acc_d        = alu_result_i;
        rsp_valid_d  = 1'b1;
        state_d      = StResp;
      end
      StResp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            issue   = 1'b1;
            state_d = StExec;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // acc_q already holds the previous result here, since EXEC updated it before RESP.
    if (issue) begin
      fifo_pop  = 1'b1;
      alu_a_d   = head_cmd.use_acc ? acc_q : head_cmd.a;
      alu_b_d   = head_cmd.b;
      alu_sel_d = head_cmd.sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      acc_q        <= acc_d;
    end
  end

  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_sel_o    = alu_sel_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_carry_o  = rsp_carry_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign acc_o        = acc_q;

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops_q, stat_carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q   <= '0;
      stat_carry_q <= '0;
    end else if (state_q == StExec) begin
      if (stat_ops_q != 16'hFFFF) stat_ops_q <= stat_ops_q + 16'd1;
      if (alu_carry_i && (stat_carry_q != 16'hFFFF)) stat_carry_q <= stat_carry_q + 16'd1;
    end
  end

  assign stat_ops_o   = stat_ops_q;
  assign stat_carry_o = stat_carry_q;
`endif

endmodule
